// File: rtl/act_buf_pkg.sv
// Shared types and elaboration helpers for the ping-pong activation buffer.
package act_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  // A frame must hold at least two words and fit within one bank.
  function automatic bit frame_len_fits(input int unsigned frame_len, input int unsigned awidth);
    return (frame_len >= 32'd2) && (frame_len <= (32'd1 << awidth));
  endfunction

endpackage

// File: rtl/act_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module act_buf_ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q;

  // Storage array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Output register holds its value while re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/act_pingpong_buf.sv
// Double-buffered activation store: AXI-Stream ingest into one bank while a
// PE reads the other; banks are handed over with valid/ack and released by done.
module act_pingpong_buf
  import act_buf_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 13,
  parameter int FRAME_LEN = 8192
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DWIDTH-1:0] ActDMA_V_V_TDATA,
  input  logic              ActDMA_V_V_TVALID,
  output logic              ActDMA_V_V_TREADY,
  output logic              bank_vld,
  output logic              bank_sel,
  input  logic              bank_ack,
  input  logic              rd_ce,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_q,
  input  logic              rd_done,
  output logic              ovf_err
);

  if (!frame_len_fits(FRAME_LEN, AWIDTH)) begin : g_bad_frame_len
    $error("act_pingpong_buf: FRAME_LEN out of range for AWIDTH");
  end

  localparam logic [AWIDTH-1:0] LAST_ADDR   = AWIDTH'(FRAME_LEN - 1);
  localparam logic [AWIDTH:0]   FRAME_LEN_W = (AWIDTH + 1)'(FRAME_LEN);
  localparam logic [AWIDTH-1:0] ADDR_ONE    = AWIDTH'(1);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic              ovf_q, ovf_d;
  logic              tready_s;
  logic              beat_s;

  assign tready_s = !ap_rst && ((state_q[wr_bank_q] == BANK_EMPTY) ||
                                (state_q[wr_bank_q] == BANK_FILLING));
  assign beat_s   = ActDMA_V_V_TVALID && tready_s;

  // Writer and reader never touch the same bank in one cycle, so both
  // updates below can be applied independently.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q | (rd_ce && ({1'b0, rd_addr} >= FRAME_LEN_W));

    if (beat_s) begin
      if (wr_addr_q == LAST_ADDR) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
        wr_addr_d          = '0;
      end else begin
        state_d[wr_bank_q] = BANK_FILLING;
        wr_addr_d          = wr_addr_q + ADDR_ONE;
      end
    end else begin
      wr_addr_d = wr_addr_q;
    end

    if (bank_ack && (state_q[rd_bank_q] == BANK_FULL)) begin
      state_d[rd_bank_q] = BANK_READING;
    end else if (rd_done && (state_q[rd_bank_q] == BANK_READING)) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Bank state machine, pointers and sticky overflow flag.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      ovf_q      <= ovf_d;
    end
  end

  act_buf_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH + 1)
  ) u_ram (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .we   (beat_s),
    .waddr({wr_bank_q, wr_addr_q}),
    .wdata(ActDMA_V_V_TDATA),
    .re   (rd_ce),
    .raddr({rd_bank_q, rd_addr}),
    .rdata(rd_q)
  );

  assign ActDMA_V_V_TREADY = tready_s;
  assign bank_vld          = (state_q[rd_bank_q] == BANK_FULL);
  assign bank_sel          = rd_bank_q;
  assign ovf_err           = ovf_q;

endmodule

// File: tb/tb_act_pingpong_buf.sv
// Directed self-checking bench for act_pingpong_buf with FRAME_LEN=4.
module tb_act_pingpong_buf;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FL = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [DW-1:0] tdata  = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          bank_vld;
  logic          bank_sel;
  logic          bank_ack = 1'b0;
  logic          rd_ce    = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic [DW-1:0] rd_q;
  logic          rd_done  = 1'b0;
  logic          ovf_err;

  int n_cmp  = 0;
  int n_fail = 0;

  act_pingpong_buf #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_LEN(FL)) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ActDMA_V_V_TDATA (tdata),
    .ActDMA_V_V_TVALID(tvalid),
    .ActDMA_V_V_TREADY(tready),
    .bank_vld         (bank_vld),
    .bank_sel         (bank_sel),
    .bank_ack         (bank_ack),
    .rd_ce            (rd_ce),
    .rd_addr          (rd_addr),
    .rd_q             (rd_q),
    .rd_done          (rd_done),
    .ovf_err          (ovf_err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    // Reset behaviour
    tick();
    tick();
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_vld", 32'(bank_vld), 32'd0);
    check("rst_sel", 32'(bank_sel), 32'd0);
    check("rst_rdq", 32'(rd_q), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    ap_rst = 1'b0;
    #1;
    check("rel_tready", 32'(tready), 32'd1);

    // First frame into bank 0 and read back
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdata = 8'(32'h10 + i);
      tick();
    end
    tvalid = 1'b0;
    check("f0_vld", 32'(bank_vld), 32'd1);
    check("f0_sel", 32'(bank_sel), 32'd0);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    check("f0_ack_vld", 32'(bank_vld), 32'd0);
    rd_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 3'(i);
      tick();
      check("f0_rd", 32'(rd_q), 32'h10 + 32'(i));
    end
    rd_ce   = 1'b0;
    rd_addr = 3'd0;
    tick();
    check("f0_hold", 32'(rd_q), 32'h13);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("f0_done_vld", 32'(bank_vld), 32'd0);
    check("f0_done_tready", 32'(tready), 32'd1);

    // Continuous stream: bank 1 fills, gets claimed, bank 0 fills, then stall
    tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdata = 8'(32'h20 + i);
      check("bp_tready_hi", 32'(tready), 32'd1);
      bank_ack = (i == 4);
      tick();
      if (i == 3) begin
        check("bp_vld1", 32'(bank_vld), 32'd1);
        check("bp_sel1", 32'(bank_sel), 32'd1);
      end
    end
    bank_ack = 1'b0;
    tdata    = 8'h28;
    check("bp_tready_lo", 32'(tready), 32'd0);
    check("bp_vld_lo", 32'(bank_vld), 32'd0);
    tick();
    tick();
    check("bp_tready_stall", 32'(tready), 32'd0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("bp_rel_tready", 32'(tready), 32'd1);
    check("bp_rel_vld", 32'(bank_vld), 32'd1);
    check("bp_rel_sel", 32'(bank_sel), 32'd0);

    // Claim bank 0 while bank 1 refills; final beat coincides with rd_done
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    tdata    = 8'h29;
    rd_ce    = 1'b1;
    rd_addr  = 3'd0;
    tick();
    check("sim_rd0", 32'(rd_q), 32'h24);
    tdata   = 8'h2A;
    rd_addr = 3'd3;
    tick();
    check("sim_rd3", 32'(rd_q), 32'h27);
    rd_ce   = 1'b0;
    tdata   = 8'h2B;
    rd_done = 1'b1;
    check("sim_tready_pre", 32'(tready), 32'd1);
    tick();
    rd_done = 1'b0;
    tvalid  = 1'b0;
    check("sim_vld", 32'(bank_vld), 32'd1);
    check("sim_sel", 32'(bank_sel), 32'd1);
    check("sim_tready", 32'(tready), 32'd1);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    rd_ce    = 1'b1;
    rd_addr  = 3'd0;
    tick();
    check("w9_bank1_rd0", 32'(rd_q), 32'h28);
    rd_addr = 3'd3;
    tick();
    check("w9_bank1_rd3", 32'(rd_q), 32'h2B);
    rd_ce   = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;

    // Reset after two beats discards the partial frame
    tvalid = 1'b1;
    tdata  = 8'h50;
    tick();
    tdata = 8'h51;
    tick();
    tvalid = 1'b0;
    ap_rst = 1'b1;
    #1;
    check("mid_rst_tready", 32'(tready), 32'd0);
    check("mid_rst_vld", 32'(bank_vld), 32'd0);
    check("mid_rst_rdq", 32'(rd_q), 32'd0);
    tick();
    ap_rst = 1'b0;
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdata = 8'(32'h60 + i);
      tick();
      if (i < 3) begin
        check("mid_partial_vld", 32'(bank_vld), 32'd0);
      end
    end
    tvalid = 1'b0;
    check("mid_full_vld", 32'(bank_vld), 32'd1);
    check("mid_full_sel", 32'(bank_sel), 32'd0);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    rd_ce    = 1'b1;
    rd_addr  = 3'd0;
    tick();
    check("mid_rd0", 32'(rd_q), 32'h60);
    rd_addr = 3'd1;
    tick();
    check("mid_rd1", 32'(rd_q), 32'h61);

    // Out-of-range read sets sticky overflow
    check("ovf_pre", 32'(ovf_err), 32'd0);
    rd_addr = 3'd5;
    tick();
    check("ovf_set", 32'(ovf_err), 32'd1);
    rd_ce   = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("ovf_done_vld", 32'(bank_vld), 32'd0);

    // Idle ack/done must be ignored
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    check("idle_ack_vld", 32'(bank_vld), 32'd0);
    check("idle_ack_tready", 32'(tready), 32'd1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("idle_done_tready", 32'(tready), 32'd1);
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdata = 8'(32'h70 + i);
      tick();
    end
    tvalid = 1'b0;
    check("idle_after_vld", 32'(bank_vld), 32'd1);
    check("idle_after_sel", 32'(bank_sel), 32'd1);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    rd_ce    = 1'b1;
    rd_addr  = 3'd2;
    tick();
    rd_ce = 1'b0;
    check("idle_after_rd2", 32'(rd_q), 32'h72);
    check("ovf_final", 32'(ovf_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
